// File: rtl/l_basic_op_unit.sv
// Registered G.729 basic-operator unit: saturating L_add, L_mult and L_shr.
// Define L_BASIC_OP_STICKY_OVF_EN for a sticky overflow flag cleared by ovf_clr.
module l_basic_op_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        ovf_clr,
   output logic [31:0] result,
   output logic        overflow,
   output logic        done
);

   typedef enum logic {StIdle, StDone} stateT;

   localparam logic [31:0] MaxPos = 32'h7FFF_FFFF;
   localparam logic [31:0] MaxNeg = 32'h8000_0000;

   stateT       state;
   logic [31:0] addSum, addRes, multA, multB, multProd, multRes;
   logic [31:0] shrRes, shlRes, shRes, opRes;
   logic [63:0] shlWide;
   logic [16:0] shlMag;
   logic [4:0]  shrAmt;
   logic        addOvf, multOvf, shlFits, shlOvf, shOvf, opOvf;

   // L_add
   assign addSum = a + b;
   assign addOvf = (a[31] == b[31]) && (addSum[31] != a[31]);
   assign addRes = addOvf ? (a[31] ? MaxNeg : MaxPos) : addSum;

   // L_mult: only 0x8000 * 0x8000 can exceed the doubled-product range
   assign multA    = {{16{a[15]}}, a[15:0]};
   assign multB    = {{16{b[15]}}, b[15:0]};
   assign multProd = multA * multB;
   assign multOvf  = (a[15:0] == 16'h8000) && (b[15:0] == 16'h8000);
   assign multRes  = multOvf ? MaxPos : (multProd << 1);

   // L_shr: counts of 31 and above fill with the sign bit
   assign shrAmt = (b[14:5] != 10'd0 || b[4:0] == 5'd31) ? 5'd31 : b[4:0];
   assign shrRes = $signed(a) >>> shrAmt;

   // Negative count: left shift by the magnitude; -32768 yields 32768
   assign shlMag  = 17'd0 - {b[15], b[15:0]};
   assign shlWide = {{32{a[31]}}, a} << shlMag[4:0];
   assign shlFits = (shlMag[16:5] == 12'd0) &&
                    ((&shlWide[63:31]) || !(|shlWide[63:31]));
   assign shlOvf  = (a != 32'd0) && !shlFits;
   assign shlRes  = (a == 32'd0) ? 32'd0 :
                    shlFits      ? shlWide[31:0] :
                    a[31]        ? MaxNeg : MaxPos;

   assign shRes = b[15] ? shlRes : shrRes;
   assign shOvf = b[15] & shlOvf;

   always_comb begin
      opRes = 32'd0;
      opOvf = 1'b0;
      unique case (op)
         2'b00: begin
            opRes = addRes;
            opOvf = addOvf;
         end
         2'b01: begin
            opRes = multRes;
            opOvf = multOvf;
         end
         2'b10: begin
            opRes = shRes;
            opOvf = shOvf;
         end
         default: begin
            opRes = 32'd0;
            opOvf = 1'b0;
         end
      endcase
   end

`ifndef L_BASIC_OP_STICKY_OVF_EN
   logic unusedOvfClr;
   assign unusedOvfClr = ovf_clr;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= StIdle;
         result   <= 32'd0;
         overflow <= 1'b0;
      end else if (start) begin
         state  <= StDone;
         result <= opRes;
`ifdef L_BASIC_OP_STICKY_OVF_EN
         overflow <= (overflow & ~ovf_clr) | opOvf;
`else
         overflow <= opOvf;
`endif
      end else begin
         state <= StIdle;
`ifdef L_BASIC_OP_STICKY_OVF_EN
         if (ovf_clr) overflow <= 1'b0;
`endif
      end
   end

   assign done = (state == StDone);

endmodule

// File: tb/tb_l_basic_op_unit.sv
// Self-checking bench for l_basic_op_unit: directed table, corner sequences and
// random operations against a range-based arithmetic model.
module tb_l_basic_op_unit;

`ifdef L_BASIC_OP_STICKY_OVF_EN
   localparam bit Sticky = 1'b1;
`else
   localparam bit Sticky = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, start, ovf_clr;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic [31:0] result;
   logic        overflow, done;

   int nChecks = 0;
   int nFail   = 0;

   l_basic_op_unit dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .ovf_clr  (ovf_clr),
      .result   (result),
      .overflow (overflow),
      .done     (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] expRes;
      logic        expOvf;
   } vecT;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference model built on 64-bit range checks
   function automatic void refOp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] res, output logic ovf);
      longint sx, p;
      int     n, m;
      sx  = longint'($signed(x));
      res = 32'd0;
      ovf = 1'b0;
      case (o)
         2'd0: begin
            p = sx + longint'($signed(y));
            if (p > 64'sd2147483647)       begin res = 32'h7FFFFFFF; ovf = 1'b1; end
            else if (p < -64'sd2147483648) begin res = 32'h80000000; ovf = 1'b1; end
            else res = 32'(p);
         end
         2'd1: begin
            p = longint'($signed(x[15:0])) * longint'($signed(y[15:0])) * 2;
            if (p > 64'sd2147483647) begin res = 32'h7FFFFFFF; ovf = 1'b1; end
            else res = 32'(p);
         end
         2'd2: begin
            n = int'($signed(y[15:0]));
            if (n >= 31) res = x[31] ? 32'hFFFFFFFF : 32'h0;
            else if (n >= 0) res = 32'(sx >>> n);
            else begin
               m = -n;
               if (sx == 0) res = 32'h0;
               else if (m >= 32) begin
                  res = x[31] ? 32'h80000000 : 32'h7FFFFFFF;
                  ovf = 1'b1;
               end else begin
                  p = sx <<< m;
                  if (p > 64'sd2147483647 || p < -64'sd2147483648) begin
                     res = x[31] ? 32'h80000000 : 32'h7FFFFFFF;
                     ovf = 1'b1;
                  end else res = 32'(p);
               end
            end
         end
         default: ;
      endcase
   endfunction

   task automatic drive(input logic s, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic clr);
      @(negedge clk);
      start = s; op = o; a = x; b = y; ovf_clr = clr;
      @(posedge clk);
      #1;
   endtask

   vecT         vecs[$];
   logic [31:0] mRes, r, opRes;
   logic        mOvf, opOvf, rs, rc;
   logic [1:0]  ro;
   logic [31:0] ra, rb;

   initial begin
      vecs.push_back('{"add_pos_sat",  2'd0, 32'h7FFFFFFF, 32'h00000001, 32'h7FFFFFFF, 1'b1});
      vecs.push_back('{"add_neg_sat",  2'd0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1});
      vecs.push_back('{"add_plain",    2'd0, 32'h00001234, 32'h00000010, 32'h00001244, 1'b0});
      vecs.push_back('{"mult_8000",    2'd1, 32'h00008000, 32'h00008000, 32'h7FFFFFFF, 1'b1});
      vecs.push_back('{"mult_4000",    2'd1, 32'h00004000, 32'h00004000, 32'h20000000, 1'b0});
      vecs.push_back('{"mult_neg",     2'd1, 32'hABCDFFFF, 32'h12340003, 32'hFFFFFFFA, 1'b0});
      vecs.push_back('{"shr_4",        2'd2, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0});
      vecs.push_back('{"shr_40",       2'd2, 32'h80000000, 32'h00000028, 32'hFFFFFFFF, 1'b0});
      vecs.push_back('{"shr_31",       2'd2, 32'h12345678, 32'h0000001F, 32'h00000000, 1'b0});
      vecs.push_back('{"shl_4",        2'd2, 32'h00010000, 32'h0000FFFC, 32'h00100000, 1'b0});
      vecs.push_back('{"shl_sat",      2'd2, 32'h40000000, 32'h0000FFFF, 32'h7FFFFFFF, 1'b1});
      vecs.push_back('{"shl_zero_max", 2'd2, 32'h00000000, 32'h00008000, 32'h00000000, 1'b0});
      vecs.push_back('{"shl_neg_fit",  2'd2, 32'hFFFFFFFF, 32'h0000FFE1, 32'h80000000, 1'b0});
      vecs.push_back('{"shl_neg_max",  2'd2, 32'h80000000, 32'h00008000, 32'h80000000, 1'b1});
      vecs.push_back('{"op_reserved",  2'd3, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000000, 1'b0});

      reset = 1'b1; start = 1'b0; ovf_clr = 1'b0; op = 2'd0; a = 32'd0; b = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_result", result, 32'd0);
      check("reset_ovf", 32'(overflow), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Directed table; ovf_clr with start leaves exactly the new op's overflow
      foreach (vecs[i]) begin
         drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b1);
         check({vecs[i].name, "_res"}, result, vecs[i].expRes);
         check({vecs[i].name, "_ovf"}, 32'(overflow), 32'(vecs[i].expOvf));
         check({vecs[i].name, "_done"}, 32'(done), 32'd1);
         drive(1'b0, 2'd0, 32'hDEADBEEF, 32'h12345678, 1'b0);
         check({vecs[i].name, "_pulse"}, 32'(done), 32'd0);
         check({vecs[i].name, "_hold"}, result, vecs[i].expRes);
      end

      // Back-to-back: overflowing add, clean mult, clean shift
      drive(1'b1, 2'd0, 32'h7FFFFFFF, 32'h00000001, 1'b0);
      check("b2b_1_done", 32'(done), 32'd1);
      check("b2b_1_res", result, 32'h7FFFFFFF);
      drive(1'b1, 2'd1, 32'h00004000, 32'h00004000, 1'b0);
      check("b2b_2_done", 32'(done), 32'd1);
      check("b2b_2_res", result, 32'h20000000);
      drive(1'b1, 2'd2, 32'h12345678, 32'h00000004, 1'b0);
      check("b2b_3_done", 32'(done), 32'd1);
      check("b2b_3_res", result, 32'h01234567);
      check("b2b_3_ovf", 32'(overflow), 32'(Sticky));
      drive(1'b0, 2'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0);
      check("b2b_end_done", 32'(done), 32'd0);
      check("b2b_end_ovf", 32'(overflow), 32'(Sticky));
      drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
      check("clr_ovf", 32'(overflow), 32'd0);
      check("clr_res_hold", result, 32'h01234567);

      // Asynchronous reset mid-cycle after a saturating op
      drive(1'b1, 2'd1, 32'h00008000, 32'h00008000, 1'b0);
      check("pre_rst_done", 32'(done), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("async_rst_result", result, 32'd0);
      check("async_rst_ovf", 32'(overflow), 32'd0);
      check("async_rst_done", 32'(done), 32'd0);
      // Start issued while reset is high must not produce a pulse
      drive(1'b1, 2'd0, 32'h00000001, 32'h00000001, 1'b0);
      check("rst_start_done", 32'(done), 32'd0);
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      @(posedge clk);
      #1;
      check("rst_start_after", 32'(done), 32'd0);
      check("rst_start_res", result, 32'd0);

      // Random operations against the model
      mRes = 32'd0;
      mOvf = 1'b0;
      for (int i = 0; i < 400; i++) begin
         rs = ($urandom_range(0, 3) != 0);
         rc = ($urandom_range(0, 4) == 0);
         ro = 2'($urandom_range(0, 3));
         r  = $urandom;
         case ($urandom_range(0, 2))
            0: ra = $urandom;
            1: ra = 32'(int'($urandom_range(0, 200)) - 100);
            default: ra = r[0] ? 32'h80000000 : 32'h7FFFFFFF;
         endcase
         r = $urandom;
         case ($urandom_range(0, 2))
            0: rb = r;
            1: rb = {r[31:16], 16'(int'($urandom_range(0, 80)) - 40)};
            default: rb = {r[31:16], r[0] ? 16'h8000 : 16'h0001};
         endcase
         drive(rs, ro, ra, rb, rc);
         if (rs) begin
            refOp(ro, ra, rb, opRes, opOvf);
            mRes = opRes;
            mOvf = Sticky ? ((mOvf & ~rc) | opOvf) : opOvf;
         end else if (Sticky && rc) begin
            mOvf = 1'b0;
         end
         check($sformatf("rnd%0d_res op%0d a=%08h b=%08h", i, ro, ra, rb), result, mRes);
         check($sformatf("rnd%0d_ovf", i), 32'(overflow), 32'(mOvf));
         check($sformatf("rnd%0d_done", i), 32'(done), 32'(rs));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
